picomem_arbiter_2_1: RTL and testbench
======================================

// Module: picomem_arbiter_2_1
// PURPOSE
//  Two-master, one-slave arbiter for the PicoMem valid/ready bus.
//  Lets the CPU (m0) and a secondary master (m1, e.g. a DMA or flash preloader) share one slave port,
//  such as the SPI flash mem port or the peripheral mux.
//  Round-robin grant, locked until the slave completes the transfer. Optional bus watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  1024          cycles in BUSY without s_ready before the watchdog fires (>=2)
//  TIMEOUT_RDATA   32'hDEADBEEF  rdata returned on a watchdog-terminated transfer
// PORTS
//  clk         in   1   system clock; all logic rising-edge
//  ext_reset   in   1   asynchronous, active-low reset
//  m0_valid    in   1   master 0 request; addr/wdata/wstrb held stable until m0_ready
//  m0_addr     in   32  master 0 address
//  m0_wdata    in   32  master 0 write data
//  m0_wstrb    in   4   master 0 byte strobes (0 = read)
//  m0_ready    out  1   master 0 completion, 1-cycle pulse
//  m0_rdata    out  32  master 0 read data, valid when m0_ready
//  m1_*        --   --  identical set for master 1
//  s_valid     out  1   slave request
//  s_addr      out  32  muxed address of the granted master
//  s_wdata     out  32  muxed write data
//  s_wstrb     out  4   muxed byte strobes
//  s_ready     in   1   slave completion; may be combinational from s_valid
//  s_rdata     in   32  slave read data
//  grant       out  1   index of the currently or last granted master
//  busy        out  1   high in BUSY
//  err         out  1   sticky watchdog flag
//  err_addr    out  32  s_addr of the first timed-out transfer
//  err_clr     in   1   clears err; err_addr keeps its value
// BEHAVIOUR
//  Reset (async): state=IDLE, grant=0, last=1 (m0 wins first tie), err=0, err_addr=0, counter=0.
//  Reset outputs: s_valid=0, m*_ready=0.
//  States: IDLE, BUSY. Both are encoded in the registered state bit.
//  IDLE:
//   - s_valid=0.
//   - If any m*_valid: pick the requester; on a tie pick !last.
//   - Register grant; last<=grant; ->BUSY.
//   - No request: stay in IDLE.
//  BUSY:
//   - s_valid = m[grant]_valid. s_addr/wdata/wstrb = m[grant] signals.
//   - s_addr/wdata/wstrb are also driven from m[grant] in IDLE, which gives stable muxing.
//   - s_ready=1: m[grant]_ready=1 in the same cycle (combinational pass-through); ->IDLE.
//   - m[grant]_valid drops without ready (protocol violation): ->IDLE, no ready issued.
//  m[grant]_rdata = s_rdata. The non-granted master sees rdata=0 and ready=0.
//  Each transfer costs 1 arbitration cycle plus the slave latency.
//  The forced IDLE cycle after each ready guarantees s_valid=0 for >=1 cycle between transfers.
//  The slave never sees back-to-back valid.
//  A master re-requesting right after its ready competes normally.
//  Under continuous contention the grants strictly alternate.
//  A request arriving while BUSY waits; its valid stays high and is not lost.
//  err_clr and a watchdog fire in the same cycle: the fire wins.
//  Reset mid-transfer: s_valid drops immediately and the master gets no ready.
// CONFIGURATION
//  Macro PICOMEM_ARB_WATCHDOG_EN.
//  Defined:
//   - Counter is cleared on entering BUSY and increments each BUSY cycle without s_ready.
//   - On count == TIMEOUT_CYCLES-1 with no s_ready:
//       m[grant]_ready=1, m[grant]_rdata=TIMEOUT_RDATA, s_valid forced 0, ->IDLE;
//       err<=1; err_addr<=s_addr if err was 0.
//   - s_ready in the fire cycle wins: normal completion, no error.
//  Undefined:
//   - No counter; BUSY waits forever.
//   - err and err_addr are tied to 0; err_clr is ignored.
// STRUCTURE
//  picomem_pkg holds:
//   - localparams ARB_IDLE/ARB_BUSY
//   - PICOMEM_DEADBEEF = 32'hDEADBEEF
//   - the wstrb read encoding 4'b0000
//  One sub-module, picomem_bus_watchdog (clk, ext_reset, start, run, done -> fire):
//   - counter width $clog2(TIMEOUT_CYCLES);
//   - instantiated only under PICOMEM_ARB_WATCHDOG_EN.
//  The arbiter core stays a single always block plus the combinational muxes.
// TESTING
//  1. m0 read of 0x4000_0010, slave ready 3 cycles after s_valid, rdata 0x12345678:
//     m0_ready pulses once with 0x12345678; m1_ready stays 0; grant=0.
//  2. m0 and m1 both valid from reset, each re-requesting continuously:
//     grant sequence 0,1,0,1; s_valid low exactly 1 cycle between transfers.
//  3. m1 write 0xCAFEBABE, wstrb=4'b0011, combinational slave (s_ready=s_valid):
//     1-cycle transfer; s_wstrb=4'b0011 seen; next IDLE cycle has s_valid=0.
//  4. Watchdog on, TIMEOUT_CYCLES=16, slave never ready, m0 addr 0x8000_0004:
//     m0_ready on BUSY cycle 16 with rdata 0xDEADBEEF; err=1; err_addr=0x8000_0004.
//     Then pulse err_clr -> err=0.
//  5. ext_reset pulsed low mid-BUSY:
//     s_valid=0 asynchronously, no ready; after release, m0 wins the first tie.
//  6. Granted m1 drops valid while BUSY with no s_ready:
//     arbiter returns to IDLE next cycle; pending m0 is granted on the following cycle.

Source files
------------

// File: rtl/picomem_pkg.sv
// Shared definitions for the PicoMem bus arbiter: state encoding, constants
// and the round-robin pick helper.
package picomem_pkg;

  typedef logic arb_state_t;

  localparam arb_state_t  ARB_IDLE           = 1'b0;
  localparam arb_state_t  ARB_BUSY           = 1'b1;
  localparam logic [31:0] PICOMEM_DEADBEEF   = 32'hDEADBEEF;
  localparam logic [3:0]  PICOMEM_WSTRB_READ = 4'b0000;

  // Round-robin choice between two requesters; a tie goes to the master not served last.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last);
    logic pick;
    if (v0 && v1) begin
      pick = ~last;
    end else if (v1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/picomem_bus_watchdog.sv
// Transfer watchdog: counts BUSY cycles without slave completion and fires
// on the last allowed cycle. Used only when PICOMEM_ARB_WATCHDOG_EN is defined.
module picomem_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic ext_reset,
  input  logic start,
  input  logic run,
  input  logic done,
  output logic fire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 32'd1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Counter register.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Clear when a transfer is granted, advance while the slave stalls.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = {CW{1'b0}};
    end else if (run && !done) begin
      count_d = count_q + CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // A slave completion in the limit cycle takes precedence over the timeout.
  assign fire = run && !done && (count_q == LIMIT);

endmodule

// File: rtl/picomem_arbiter_2_1.sv
// Two-master, one-slave round-robin arbiter for the PicoMem valid/ready bus.
// Optional bus watchdog enabled by defining PICOMEM_ARB_WATCHDOG_EN.
module picomem_arbiter_2_1
  import picomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = PICOMEM_DEADBEEF
) (
  input  logic        clk,
  input  logic        ext_reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  arb_state_t  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        busy_s;
  logic        g_valid_s;
  logic [31:0] g_addr_s;
  logic        start_s;
  logic        pick_s;
  logic        complete_s;
  logic        fire_s;
  logic [31:0] rdata_s;

  assign busy_s     = (state_q == ARB_BUSY);
  assign g_valid_s  = grant_q ? m1_valid : m0_valid;
  assign g_addr_s   = grant_q ? m1_addr : m0_addr;
  assign start_s    = (state_q == ARB_IDLE) && (m0_valid || m1_valid);
  assign pick_s     = arb_pick(m0_valid, m1_valid, last_q);
  assign complete_s = busy_s && g_valid_s && s_ready;

`ifdef PICOMEM_ARB_WATCHDOG_EN
  picomem_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .ext_reset(ext_reset),
    .start    (start_s),
    .run      (busy_s && g_valid_s),
    .done     (s_ready),
    .fire     (fire_s)
  );
`else
  logic unused_cfg_s;
  assign fire_s       = 1'b0;
  assign unused_cfg_s = err_clr ^ TIMEOUT_CYCLES[0];
`endif

  assign rdata_s = fire_s ? TIMEOUT_RDATA : s_rdata;

  // State and status registers.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant until completion, timeout or abandonment.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      ARB_IDLE: begin
        if (start_s) begin
          state_d = ARB_BUSY;
          grant_d = pick_s;
          last_d  = pick_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (complete_s || fire_s || !g_valid_s) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
`ifdef PICOMEM_ARB_WATCHDOG_EN
    // A timeout in the same cycle as err_clr keeps the flag set.
    if (fire_s) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_addr_d = g_addr_s;
      end else begin
        err_addr_d = err_addr_q;
      end
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
`else
    err_d      = 1'b0;
    err_addr_d = 32'h0000_0000;
`endif
  end

  // Output muxes: the slave sees the granted master, only the granted master sees the response.
  always_comb begin
    s_valid = busy_s && g_valid_s && !fire_s;
    s_addr  = g_addr_s;
    s_wdata = grant_q ? m1_wdata : m0_wdata;
    s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
    if (grant_q == 1'b0) begin
      m0_ready = complete_s || fire_s;
      m0_rdata = rdata_s;
      m1_ready = 1'b0;
      m1_rdata = 32'h0000_0000;
    end else begin
      m0_ready = 1'b0;
      m0_rdata = 32'h0000_0000;
      m1_ready = complete_s || fire_s;
      m1_rdata = rdata_s;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_s;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// Directed bench for picomem_arbiter_2_1 with a response scoreboard.
// Define PICOMEM_ARB_WATCHDOG_EN to exercise the watchdog path.
module tb_picomem_arbiter_2_1;
  import picomem_pkg::*;

  logic        clk = 1'b0;
  logic        ext_reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready, s_ready_drv, comb_slave;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        grant, busy, err, err_clr;
  logic [31:0] err_addr;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  assign s_ready = comb_slave ? s_valid : s_ready_drv;

  picomem_arbiter_2_1 #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .ext_reset(ext_reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy), .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic id, input logic [31:0] data);
    sb_item_t it;
    it.id   = id;
    it.data = data;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic id, input logic [31:0] data);
    sb_item_t it;
    check1("sb_expected_ready", sb_q.size() > 0, 1'b1);
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check1("sb_master", id, it.id);
      check32("sb_rdata", data, it.data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard consumer: every ready pulse must match the next expected response.
  always @(negedge clk) begin
    if (m0_ready === 1'b1) sb_pop(1'b0, m0_rdata);
    if (m1_ready === 1'b1) sb_pop(1'b1, m1_rdata);
  end

  initial begin
    ext_reset = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = PICOMEM_WSTRB_READ;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = PICOMEM_WSTRB_READ;
    s_ready_drv = 1'b0; comb_slave = 1'b0; s_rdata = 32'h0; err_clr = 1'b0;

    // Reset state
    #12;
    check1("rst_s_valid", s_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_grant", grant, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_err_addr", err_addr, 32'h0);
    check1("rst_m0_ready", m0_ready, 1'b0);
    check1("rst_m1_ready", m1_ready, 1'b0);
    ext_reset = 1'b1;

    // 1: m0 read, slave answers 3 cycles after s_valid
    m0_valid = 1'b1; m0_addr = 32'h4000_0010;
    sb_push(1'b0, 32'h1234_5678);
    #1 check1("t1_idle_s_valid", s_valid, 1'b0);
    tick();
    #1 check1("t1_busy", busy, 1'b1);
    check1("t1_s_valid", s_valid, 1'b1);
    check32("t1_s_addr", s_addr, 32'h4000_0010);
    check1("t1_grant", grant, 1'b0);
    tick();
    tick();
    tick();
    s_ready_drv = 1'b1; s_rdata = 32'h1234_5678;
    #1 check1("t1_m0_ready", m0_ready, 1'b1);
    check32("t1_m0_rdata", m0_rdata, 32'h1234_5678);
    check1("t1_m1_ready", m1_ready, 1'b0);
    tick();
    s_ready_drv = 1'b0; m0_valid = 1'b0;
    #1 check1("t1_after_s_valid", s_valid, 1'b0);
    check1("t1_after_busy", busy, 1'b0);

    // 2: continuous contention from reset, combinational slave
    ext_reset = 1'b0;
    #1 check1("t2_rst_grant", grant, 1'b0);
    ext_reset = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    comb_slave = 1'b1;
    s_rdata = 32'hA000_0000;
    sb_push(1'b0, 32'hA000_0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 check1("t2_grant", grant, k[0]);
      check1("t2_s_valid_busy", s_valid, 1'b1);
      check32("t2_s_addr", s_addr, k[0] ? 32'h0000_0200 : 32'h0000_0100);
      tick();
      #1 check1("t2_s_valid_gap", s_valid, 1'b0);
      if (k == 3) begin
        m0_valid = 1'b0; m1_valid = 1'b0;
      end else begin
        s_rdata = 32'hA000_0000 + 32'(k + 1);
        sb_push(~k[0], 32'hA000_0000 + 32'(k + 1));
      end
    end

    // 3: m1 write through a combinational slave
    m1_valid = 1'b1; m1_addr = 32'h1000_0020; m1_wdata = 32'hCAFE_BABE; m1_wstrb = 4'b0011;
    s_rdata = 32'h5555_AAAA;
    sb_push(1'b1, 32'h5555_AAAA);
    tick();
    #1 check32("t3_s_wstrb", {28'h0, s_wstrb}, 32'h0000_0003);
    check32("t3_s_wdata", s_wdata, 32'hCAFE_BABE);
    check1("t3_m1_ready", m1_ready, 1'b1);
    check1("t3_m0_ready", m0_ready, 1'b0);
    check32("t3_m0_rdata", m0_rdata, 32'h0);
    tick();
    m1_valid = 1'b0; m1_wstrb = PICOMEM_WSTRB_READ;
    #1 check1("t3_idle_s_valid", s_valid, 1'b0);
    check1("t3_idle_busy", busy, 1'b0);
    comb_slave = 1'b0;

    // 4: slave never answers
    m0_valid = 1'b1; m0_addr = 32'h8000_0004;
`ifdef PICOMEM_ARB_WATCHDOG_EN
    sb_push(1'b0, 32'hDEAD_BEEF);
    tick();
    for (int i = 1; i < 16; i++) begin
      #1 check1("t4_wait_m0_ready", m0_ready, 1'b0);
      tick();
    end
    #1 check1("t4_fire_m0_ready", m0_ready, 1'b1);
    check32("t4_fire_rdata", m0_rdata, 32'hDEAD_BEEF);
    check1("t4_fire_s_valid", s_valid, 1'b0);
    tick();
    m0_valid = 1'b0;
    #1 check1("t4_err", err, 1'b1);
    check32("t4_err_addr", err_addr, 32'h8000_0004);
    check1("t4_busy", busy, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 check1("t4_err_clr", err, 1'b0);
    check32("t4_err_addr_kept", err_addr, 32'h8000_0004);
`else
    tick();
    for (int i = 1; i <= 20; i++) begin
      #1 check1("t4_wait_m0_ready", m0_ready, 1'b0);
      check1("t4_wait_busy", busy, 1'b1);
      tick();
    end
    err_clr = 1'b1;
    #1 check1("t4_err", err, 1'b0);
    check32("t4_err_addr", err_addr, 32'h0);
    s_ready_drv = 1'b1; s_rdata = 32'h0BAD_F00D;
    sb_push(1'b0, 32'h0BAD_F00D);
    #1 check1("t4_late_m0_ready", m0_ready, 1'b1);
    tick();
    err_clr = 1'b0; s_ready_drv = 1'b0; m0_valid = 1'b0;
    #1 check1("t4_idle_busy", busy, 1'b0);
    check1("t4_idle_err", err, 1'b0);
`endif

    // 5: reset asserted in the middle of a transfer
    m1_valid = 1'b1; m1_addr = 32'h0000_0300;
    tick();
    #1 check1("t5_grant_m1", grant, 1'b1);
    check1("t5_s_valid", s_valid, 1'b1);
    ext_reset = 1'b0;
    #1 check1("t5_rst_s_valid", s_valid, 1'b0);
    check1("t5_rst_m1_ready", m1_ready, 1'b0);
    check1("t5_rst_busy", busy, 1'b0);
    m0_valid = 1'b1; m0_addr = 32'h0000_0400;
    #3 ext_reset = 1'b1;
    tick();
    #1 check1("t5_tie_grant", grant, 1'b0);
    check1("t5_busy", busy, 1'b1);
    sb_push(1'b0, 32'h1111_2222);
    s_rdata = 32'h1111_2222; s_ready_drv = 1'b1;
    #1 check1("t5_m0_ready", m0_ready, 1'b1);
    tick();
    s_ready_drv = 1'b0; m0_valid = 1'b0;
    #1 check1("t5_idle_busy", busy, 1'b0);

    // 6: granted m1 abandons its request while m0 waits
    tick();
    #1 check1("t6_grant_m1", grant, 1'b1);
    m0_valid = 1'b1; m0_addr = 32'h0000_0500;
    tick();
    #1 check1("t6_still_busy", busy, 1'b1);
    check1("t6_pending_m0_ready", m0_ready, 1'b0);
    check1("t6_grant_held", grant, 1'b1);
    m1_valid = 1'b0;
    #1 check1("t6_drop_s_valid", s_valid, 1'b0);
    check1("t6_drop_m1_ready", m1_ready, 1'b0);
    tick();
    #1 check1("t6_idle_busy", busy, 1'b0);
    check1("t6_idle_s_valid", s_valid, 1'b0);
    tick();
    #1 check1("t6_grant_m0", grant, 1'b0);
    check32("t6_s_addr", s_addr, 32'h0000_0500);
    sb_push(1'b0, 32'h600D_CAFE);
    s_rdata = 32'h600D_CAFE; s_ready_drv = 1'b1;
    #1 check1("t6_m0_ready", m0_ready, 1'b1);
    tick();
    s_ready_drv = 1'b0; m0_valid = 1'b0;
    #1 check1("t6_end_busy", busy, 1'b0);
    tick();
    tick();
    check32("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
